// File: rtl/nios_cpu_div_cell_if.sv
// Divider cell request/response bundle between the A-stage execute unit and the divider.
interface nios_cpu_div_cell_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  A_div_start;
    logic                  A_div_signed;
    logic [DATA_WIDTH-1:0] A_div_src1;
    logic [DATA_WIDTH-1:0] A_div_src2;
    logic                  A_div_busy;
    logic                  A_div_done;
    logic [DATA_WIDTH-1:0] A_div_quotient;
    logic [DATA_WIDTH-1:0] A_div_remainder;
    logic                  A_div_by_zero;

    // Execute unit side: issues operations, observes results.
    modport master (
        output A_div_start, A_div_signed, A_div_src1, A_div_src2,
        input  A_div_busy, A_div_done, A_div_quotient, A_div_remainder, A_div_by_zero
    );

    // Divider side.
    modport slave (
        input  A_div_start, A_div_signed, A_div_src1, A_div_src2,
        output A_div_busy, A_div_done, A_div_quotient, A_div_remainder, A_div_by_zero
    );
endinterface

// File: rtl/nios_cpu_div_cell.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, fixed latency,
// signed/unsigned, quotient/remainder/by_zero held until the next operation finishes.
module nios_cpu_div_cell #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    nios_cpu_div_cell_if.slave        div_if
);

    localparam int unsigned N     = DATA_WIDTH;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIXUP,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     src1_q, src1_d;      // original dividend, returned on divide-by-zero
    logic [N-1:0]     dvd_q, dvd_d;        // working dividend, becomes the quotient
    logic [N-1:0]     dvsr_q, dvsr_d;      // raw divisor at accept, magnitude after PREP
    logic [N-1:0]     rem_q, rem_d;        // partial remainder (always < divisor)
    logic             signed_q, signed_d;
    logic             sd_q, sd_d;
    logic             sv_q, sv_d;
    logic             byz_next_q, byz_next_d;
    logic [N-1:0]     quo_q, quo_d;
    logic [N-1:0]     rmd_q, rmd_d;
    logic             byz_q, byz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [N:0]       rem_sh;
    logic [N:0]       diff;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            src1_q     <= '0;
            dvd_q      <= '0;
            dvsr_q     <= '0;
            rem_q      <= '0;
            signed_q   <= 1'b0;
            sd_q       <= 1'b0;
            sv_q       <= 1'b0;
            byz_next_q <= 1'b0;
            quo_q      <= '0;
            rmd_q      <= '0;
            byz_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src1_q     <= src1_d;
            dvd_q      <= dvd_d;
            dvsr_q     <= dvsr_d;
            rem_q      <= rem_d;
            signed_q   <= signed_d;
            sd_q       <= sd_d;
            sv_q       <= sv_d;
            byz_next_q <= byz_next_d;
            quo_q      <= quo_d;
            rmd_q      <= rmd_d;
            byz_q      <= byz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state, datapath step and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src1_d     = src1_q;
        dvd_d      = dvd_q;
        dvsr_d     = dvsr_q;
        rem_d      = rem_q;
        signed_d   = signed_q;
        sd_d       = sd_q;
        sv_d       = sv_q;
        byz_next_d = byz_next_q;
        quo_d      = quo_q;
        rmd_d      = rmd_q;
        byz_d      = byz_q;
        rem_sh     = '0;
        diff       = '0;

        case (state_q)
            // DONE shares the accept path so a start in the done cycle chains directly.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (div_if.A_div_start) begin
                    src1_d   = div_if.A_div_src1;
                    dvsr_d   = div_if.A_div_src2;
                    signed_d = div_if.A_div_signed;
                    state_d  = S_PREP;
                end
            end

            // Signs and magnitudes; -2^(N-1) maps onto 2^(N-1) as an unsigned value.
            S_PREP: begin
                sd_d       = signed_q & src1_q[N-1];
                sv_d       = signed_q & dvsr_q[N-1];
                dvd_d      = sd_d ? (~src1_q + N'(1)) : src1_q;
                dvsr_d     = sv_d ? (~dvsr_q + N'(1)) : dvsr_q;
                byz_next_d = (dvsr_q == '0);
                rem_d      = '0;
                cnt_d      = CNT_W'(N - 1);
                state_d    = S_ITER;
            end

            // Shift {rem, dvd} left, trial-subtract, restore on a negative difference.
            S_ITER: begin
                rem_sh = {rem_q, dvd_q[N-1]};
                diff   = rem_sh - {1'b0, dvsr_q};
                if (!diff[N]) begin
                    rem_d = diff[N-1:0];
                    dvd_d = {dvd_q[N-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[N-1:0];
                    dvd_d = {dvd_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIXUP;
                end
            end

            // Apply signs (sd/sv are only ever set in signed mode) or the by-zero result.
            S_FIXUP: begin
                if (byz_next_q) begin
                    quo_d = '1;
                    rmd_d = src1_q;
                    byz_d = 1'b1;
                end else begin
                    quo_d = (sd_q ^ sv_q) ? (~dvd_q + N'(1)) : dvd_q;
                    rmd_d = sd_q ? (~rem_q + N'(1)) : rem_q;
                    byz_d = 1'b0;
                end
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_PREP) || (state_d == S_ITER) || (state_d == S_FIXUP);
        done_d = (state_d == S_DONE);
    end

    assign div_if.A_div_busy      = busy_q;
    assign div_if.A_div_done      = done_q;
    assign div_if.A_div_quotient  = quo_q;
    assign div_if.A_div_remainder = rmd_q;
    assign div_if.A_div_by_zero   = byz_q;

endmodule
